// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, IF/ID hold buffer, redirect drain.
// Optional FETCH_ALIGN_CHECK_EN masks odd redirect targets and raises a sticky err_misalign.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        valid_out,
    output logic [15:0] instruction_out,
    output logic [15:0] PC_next_out,
    output logic [15:0] PC_NO_PLUS_TWO_OUT,
    output logic        err_misalign
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_buf;
    logic [15:0] w_buf_nxt;
    logic [15:0] r_drain_addr;
    logic [15:0] w_drain_nxt;
    logic [15:0] w_redir_pc;
    logic [15:0] w_pc_inc;
    logic [15:0] w_addr;
    logic [15:0] w_word;
    logic        w_req;
    logic        w_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_err;

    assign w_redir_pc   = {redirect_pc[15:1], 1'b0};
    assign err_misalign = r_err;

    always_ff @(posedge clk) begin
        if (!rst)
            r_err <= 1'b0;
        else if (redirect_valid && redirect_pc[0])
            r_err <= 1'b1;
    end
`else
    assign w_redir_pc   = redirect_pc;
    assign err_misalign = 1'b0;
`endif

    assign w_pc_inc = r_pc + 16'd2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_pc         <= 16'h0000;
            r_buf        <= NOP;
            r_drain_addr <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_buf        <= w_buf_nxt;
            r_drain_addr <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_drain_nxt = r_drain_addr;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_valid     = 1'b0;
        w_word      = r_buf;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                    w_buf_nxt = NOP;
                    if (imem_done) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_drain_nxt = r_pc;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (imem_done) begin
                    if (stall_in) begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_valid     = 1'b1;
                        w_word      = imem_rdata;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = (imem_rdata[15:11] == 5'b00000)
                                      ? S_HALTED : S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_buf_nxt   = NOP;
                    w_state_nxt = S_FETCH;
                end else if (!stall_in) begin
                    w_valid     = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = (r_buf[15:11] == 5'b00000)
                                  ? S_HALTED : S_FETCH;
                end
            end
            // Keep the abandoned address on the bus until memory completes it
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (redirect_valid)
                    w_pc_nxt = w_redir_pc;
                if (imem_done)
                    w_state_nxt = S_FETCH;
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    assign imem_req           = rst & w_req;
    assign imem_addr          = rst ? w_addr : 16'h0000;
    assign valid_out          = rst & w_valid;
    assign instruction_out    = valid_out ? w_word : NOP;
    assign PC_NO_PLUS_TWO_OUT = rst ? r_pc : 16'h0000;
    assign PC_next_out        = rst ? w_pc_inc : 16'h0000;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, stall hold, redirect drain, halt, wrap,
// and misaligned redirect (expectations follow FETCH_ALIGN_CHECK_EN).
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        stall_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        valid_out;
    logic [15:0] instruction_out;
    logic [15:0] PC_next_out;
    logic [15:0] PC_NO_PLUS_TWO_OUT;
    logic        err_misalign;

    int n_vec;
    int n_err;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [15:0] MIS_ADDR = 16'h0030;
    localparam logic [15:0] MIS_ERR  = 16'h0001;
`else
    localparam logic [15:0] MIS_ADDR = 16'h0031;
    localparam logic [15:0] MIS_ERR  = 16'h0000;
`endif

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_done         (imem_done),
        .stall_in          (stall_in),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .valid_out         (valid_out),
        .instruction_out   (instruction_out),
        .PC_next_out       (PC_next_out),
        .PC_NO_PLUS_TWO_OUT(PC_NO_PLUS_TWO_OUT),
        .err_misalign      (err_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic done, input logic [15:0] rdata,
                         input logic stall, input logic rv,
                         input logic [15:0] rpc);
        @(negedge clk);
        imem_done      = done;
        imem_rdata     = rdata;
        stall_in       = stall;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        imem_done = 1'b0;
        imem_rdata = 16'h0;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;

        drive(0, 16'h0, 0, 0, 16'h0);
        check("rst_req", {15'b0, imem_req}, 16'h0);
        check("rst_valid", {15'b0, valid_out}, 16'h0);
        check("rst_instr", instruction_out, 16'h0800);
        check("rst_pcn", PC_next_out, 16'h0000);
        check("rst_pc", PC_NO_PLUS_TWO_OUT, 16'h0000);
        check("rst_err", {15'b0, err_misalign}, 16'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("first_req", {15'b0, imem_req}, 16'h1);
        check("first_addr", imem_addr, 16'h0000);
        check("wait_valid", {15'b0, valid_out}, 16'h0);

        drive(1, 16'h4000, 0, 0, 16'h0);
        check("f0_valid", {15'b0, valid_out}, 16'h1);
        check("f0_instr", instruction_out, 16'h4000);
        check("f0_pc", PC_NO_PLUS_TWO_OUT, 16'h0000);
        check("f0_pcn", PC_next_out, 16'h0002);

        drive(0, 16'h0, 0, 0, 16'h0);
        check("f1_addr", imem_addr, 16'h0002);

        drive(1, 16'h5000, 1, 0, 16'h0);
        check("st0_valid", {15'b0, valid_out}, 16'h0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 16'h0, 1, 0, 16'h0);
            check("hold_req", {15'b0, imem_req}, 16'h0);
            check("hold_valid", {15'b0, valid_out}, 16'h0);
        end
        drive(0, 16'h0, 0, 0, 16'h0);
        check("hold_rel_valid", {15'b0, valid_out}, 16'h1);
        check("hold_rel_instr", instruction_out, 16'h5000);
        check("hold_rel_pc", PC_NO_PLUS_TWO_OUT, 16'h0002);
        check("hold_rel_req", {15'b0, imem_req}, 16'h0);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("after_hold_addr", imem_addr, 16'h0004);

        drive(1, 16'h6000, 0, 1, 16'h0010);
        check("redir_done_valid", {15'b0, valid_out}, 16'h0);
        check("redir_done_instr", instruction_out, 16'h0800);
        drive(0, 16'h0, 0, 1, 16'h0100);
        check("pend_addr", imem_addr, 16'h0010);
        check("pend_valid", {15'b0, valid_out}, 16'h0);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("drain_req", {15'b0, imem_req}, 16'h1);
        check("drain_addr", imem_addr, 16'h0010);
        drive(1, 16'h4444, 0, 0, 16'h0);
        check("drain_drop", {15'b0, valid_out}, 16'h0);
        check("drain_addr2", imem_addr, 16'h0010);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("post_drain_addr", imem_addr, 16'h0100);

        drive(1, 16'h0000, 0, 0, 16'h0);
        check("halt_valid", {15'b0, valid_out}, 16'h1);
        check("halt_instr", instruction_out, 16'h0000);
        drive(1, 16'h4000, 0, 0, 16'h0);
        check("halted_req", {15'b0, imem_req}, 16'h0);
        check("halted_valid", {15'b0, valid_out}, 16'h0);
        drive(0, 16'h0, 0, 1, 16'h0040);
        check("halted_redir_valid", {15'b0, valid_out}, 16'h0);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("resume_req", {15'b0, imem_req}, 16'h1);
        check("resume_addr", imem_addr, 16'h0040);

        drive(1, 16'h4000, 0, 1, 16'hFFFE);
        check("to_top_valid", {15'b0, valid_out}, 16'h0);
        drive(1, 16'h4000, 0, 0, 16'h0);
        check("wrap_pc", PC_NO_PLUS_TWO_OUT, 16'hFFFE);
        check("wrap_pcn", PC_next_out, 16'h0000);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("wrap_addr", imem_addr, 16'h0000);

        drive(1, 16'h4000, 0, 1, 16'h0031);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("mis_addr", imem_addr, MIS_ADDR);
        check("mis_err", {15'b0, err_misalign}, MIS_ERR);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_req", {15'b0, imem_req}, 16'h0);
        check("rst2_pc", PC_NO_PLUS_TWO_OUT, 16'h0000);
        drive(0, 16'h0, 0, 0, 16'h0);
        check("rst2_err", {15'b0, err_misalign}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2_addr", imem_addr, 16'h0000);
        check("rst2_req_on", {15'b0, imem_req}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
